bounce_ctrl: RTL and testbench

- Game sequencer for the bouncing-ball datapath.
- Debounces the player button and runs the game FSM (IDLE/PLAY/PAUSE/OVER).
- Paces the ball datapath with a per-N-frame step enable and issues ball reload pulses.
- Tracks score and lives.
- Sits between the raw board button, the VGA frame tick and the `bounce` position datapath.

---
 rtl/bounce_ctrl.sv | 166 ++++++++++++++++
 tb/tb_bounce_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bounce_ctrl.sv
// bounce_ctrl: debounced start/pause button, IDLE/PLAY/PAUSE/OVER game FSM, ball step pacing, score and lives.
// Optional macro BOUNCE_SPEEDUP_EN: step divider shrinks by one each time the score passes a multiple of 8.
module bounce_ctrl #(
    parameter int         DEBOUNCE_CYCLES = 250000,
    parameter int         FRAME_DIV       = 2,
    parameter int         START_LIVES     = 3,
    parameter logic [8:0] Y_FLOOR         = 9'd470
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn,
    input  logic       frame_tick,
    input  logic [8:0] ball_y,
    input  logic       paddle_hit,
    output logic       step_en,
    output logic       ball_load,
    output logic [1:0] state,
    output logic [7:0] score,
    output logic [1:0] lives,
    output logic       game_over
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        PAUSE = 2'd2,
        OVER  = 2'd3
    } state_t;

    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int CW  = $clog2(FRAME_DIV + 1);
    localparam logic [DBW-1:0] DEB_LAST   = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0]  DIV_INIT   = CW'(FRAME_DIV);
    localparam logic [1:0]     LIVES_INIT = 2'(START_LIVES);

    state_t         st;
    logic           sync1, sync2;
    logic           deb, deb_d, btn_press;
    logic [DBW-1:0] deb_cnt;
    logic [CW-1:0]  fcnt;
    logic [CW-1:0]  div_m1;
    logic [1:0]     holdoff;
    logic           miss;
    logic           hit_ok;

    assign state  = st;
    assign miss   = (ball_y >= Y_FLOOR) && (holdoff == 2'd0);
    assign hit_ok = paddle_hit && (score != 8'hFF);

`ifdef BOUNCE_SPEEDUP_EN
    logic [CW-1:0] div_q;
    assign div_m1 = div_q - 1'b1;
`else
    assign div_m1 = DIV_INIT - 1'b1;
`endif

    // The synced level must disagree with the accepted level for DEBOUNCE_CYCLES
    // consecutive cycles before it is accepted; the press pulse follows one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            deb       <= 1'b0;
            deb_d     <= 1'b0;
            deb_cnt   <= '0;
            btn_press <= 1'b0;
        end else begin
            sync1     <= btn;
            sync2     <= sync1;
            deb_d     <= deb;
            btn_press <= deb & ~deb_d;
            if (sync2 == deb) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                deb     <= sync2;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st        <= IDLE;
            score     <= 8'd0;
            lives     <= 2'd0;
            step_en   <= 1'b0;
            ball_load <= 1'b0;
            game_over <= 1'b0;
            fcnt      <= '0;
            holdoff   <= 2'd0;
`ifdef BOUNCE_SPEEDUP_EN
            div_q     <= DIV_INIT;
`endif
        end else begin
            step_en   <= 1'b0;
            ball_load <= 1'b0;
            // Holdoff starts counting only after the reload pulse has been seen by the datapath.
            if (holdoff != 2'd0 && !ball_load) begin
                holdoff <= holdoff - 2'd1;
            end
            case (st)
                IDLE: begin
                    if (btn_press) begin
                        st        <= PLAY;
                        score     <= 8'd0;
                        lives     <= LIVES_INIT;
                        fcnt      <= '0;
                        holdoff   <= 2'd0;
                        ball_load <= 1'b1;
`ifdef BOUNCE_SPEEDUP_EN
                        div_q     <= DIV_INIT;
`endif
                    end
                end
                PLAY: begin
                    if (miss) begin
                        if (lives > 2'd1) begin
                            lives     <= lives - 2'd1;
                            ball_load <= 1'b1;
                            holdoff   <= 2'd3;
                        end else begin
                            lives     <= 2'd0;
                            st        <= OVER;
                            game_over <= 1'b1;
                        end
                    end else begin
                        if (hit_ok) begin
                            score <= score + 8'd1;
`ifdef BOUNCE_SPEEDUP_EN
                            if (score[2:0] == 3'd7 && div_q > CW'(1)) begin
                                div_q <= div_q - 1'b1;
                            end
`endif
                        end
                        if (btn_press) begin
                            st <= PAUSE;
                        end else if (frame_tick) begin
                            // >= keeps pacing sane if the divider shrinks below a running count
                            if (fcnt >= div_m1) begin
                                fcnt    <= '0;
                                step_en <= 1'b1;
                            end else begin
                                fcnt <= fcnt + 1'b1;
                            end
                        end
                    end
                end
                PAUSE: begin
                    if (btn_press) begin
                        st <= PLAY;
                    end
                end
                OVER: begin
                    if (btn_press) begin
                        st        <= IDLE;
                        game_over <= 1'b0;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bounce_ctrl.sv
// Bench for bounce_ctrl: game-level reference model compared every cycle, plus directed literal checks.
module tb_bounce_ctrl;

    localparam int D  = 4;
    localparam int FD = 2;
    localparam int SL = 3;
`ifdef BOUNCE_SPEEDUP_EN
    localparam int EXP_STEPS = 4;
`else
    localparam int EXP_STEPS = 2;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       btn = 1'b0;
    logic       frame_tick = 1'b0;
    logic       paddle_hit = 1'b0;
    logic [8:0] ball_y = 9'd100;
    logic       step_en, ball_load, game_over;
    logic [1:0] state, lives;
    logic [7:0] score;

    int n_err = 0;
    int n_chk = 0;
    int step_cnt = 0;
    int load_cnt = 0;

    bounce_ctrl #(
        .DEBOUNCE_CYCLES(D),
        .FRAME_DIV(FD),
        .START_LIVES(SL),
        .Y_FLOOR(9'd470)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .btn(btn),
        .frame_tick(frame_tick),
        .ball_y(ball_y),
        .paddle_hit(paddle_hit),
        .step_en(step_en),
        .ball_load(ball_load),
        .state(state),
        .score(score),
        .lives(lives),
        .game_over(game_over)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: game rules stated directly on integers.
    int m_state = 0, m_score = 0, m_lives = 0, m_step = 0, m_load = 0;
    int m_frames = 0, m_mask = 0, m_div = FD;
    int b_hist0 = 0, b_hist1 = 0, b_lvl = 0, b_run = 0, b_rose = 0, b_press = 0;
    int seen, pr;
    bit miss;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state = 0; m_score = 0; m_lives = 0; m_step = 0; m_load = 0;
            m_frames = 0; m_mask = 0; m_div = FD;
            b_hist0 = 0; b_hist1 = 0; b_lvl = 0; b_run = 0; b_rose = 0; b_press = 0;
        end else begin
            pr = b_press;
            // debouncer sees the button two cycles late; acceptance after D agreeing samples
            seen = b_hist1;
            b_hist1 = b_hist0;
            b_hist0 = int'(btn);
            b_press = b_rose;
            b_rose = 0;
            if (seen != b_lvl) begin
                b_run++;
                if (b_run == D) begin
                    b_lvl = seen;
                    b_run = 0;
                    b_rose = seen;
                end
            end else begin
                b_run = 0;
            end

            m_step = 0;
            m_load = 0;
            miss = (ball_y >= 470) && (m_mask == 0);
            if (m_mask > 0) m_mask--;
            case (m_state)
                0: if (pr != 0) begin
                    m_state = 1; m_score = 0; m_lives = SL; m_frames = 0;
                    m_load = 1; m_mask = 0; m_div = FD;
                end
                1: if (miss) begin
                    if (m_lives > 1) begin
                        m_lives--; m_load = 1; m_mask = 4;
                    end else begin
                        m_lives = 0; m_state = 3;
                    end
                end else begin
                    if (paddle_hit && m_score < 255) begin
                        m_score++;
`ifdef BOUNCE_SPEEDUP_EN
                        if (m_score % 8 == 0 && m_div > 1) m_div--;
`endif
                    end
                    if (pr != 0) m_state = 2;
                    else if (frame_tick) begin
                        m_frames++;
                        if (m_frames >= m_div) begin
                            m_frames = 0;
                            m_step = 1;
                        end
                    end
                end
                2: if (pr != 0) m_state = 1;
                default: if (pr != 0) m_state = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        chk("state", int'(state), m_state);
        chk("score", int'(score), m_score);
        chk("lives", int'(lives), m_lives);
        chk("step_en", int'(step_en), m_step);
        chk("ball_load", int'(ball_load), m_load);
        chk("game_over", int'(game_over), (m_state == 3) ? 1 : 0);
        if (step_en) step_cnt++;
        if (ball_load) load_cnt++;
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic press_btn();
        btn = 1'b1;
        repeat (10) cyc();
        btn = 1'b0;
        repeat (10) cyc();
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        repeat (2) cyc();
    endtask

    task automatic hits(input int n);
        repeat (n) begin
            paddle_hit = 1'b1;
            cyc();
        end
        paddle_hit = 1'b0;
        cyc();
    endtask

    task automatic miss5();
        ball_y = 9'd475;
        repeat (5) cyc();
        ball_y = 9'd100;
        repeat (5) cyc();
    endtask

    int s0, l0;

    initial begin
        #1 rst_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            btn = ~btn;
        end
        btn = 1'b0;
        cyc();
        chk("rst_state", int'(state), 0);
        chk("rst_lives", int'(lives), 0);
        chk("rst_score", int'(score), 0);
        rst_n = 1'b1;
        s0 = step_cnt; l0 = load_cnt;
        repeat (8) cyc();
        chk("release_steps", step_cnt - s0, 0);
        chk("release_loads", load_cnt - l0, 0);

        // bouncing press: 1-0-1 then a clean hold
        l0 = load_cnt;
        btn = 1'b1; cyc();
        btn = 1'b0; cyc();
        btn = 1'b1;
        repeat (10) cyc();
        btn = 1'b0;
        repeat (10) cyc();
        chk("start_state", int'(state), 1);
        chk("start_lives", int'(lives), 3);
        chk("start_loads", load_cnt - l0, 1);

        s0 = step_cnt;
        repeat (6) tick();
        chk("six_ticks_steps", step_cnt - s0, 3);
        hits(3);
        chk("three_hits", int'(score), 3);

        l0 = load_cnt;
        miss5();
        chk("miss1_lives", int'(lives), 2);
        chk("miss1_loads", load_cnt - l0, 1);
        miss5();
        chk("miss2_lives", int'(lives), 1);
        l0 = load_cnt;
        miss5();
        chk("miss3_lives", int'(lives), 0);
        chk("miss3_state", int'(state), 3);
        chk("miss3_over", int'(game_over), 1);
        chk("miss3_loads", load_cnt - l0, 0);
        press_btn();
        chk("over_to_idle", int'(state), 0);
        chk("idle_score_kept", int'(score), 3);

        // pause freezes the frame count
        press_btn();
        chk("game2_score", int'(score), 0);
        tick();
        press_btn();
        chk("pause_state", int'(state), 2);
        s0 = step_cnt;
        hits(1);
        ball_y = 9'd475; repeat (2) cyc(); ball_y = 9'd100; cyc();
        repeat (3) tick();
        chk("pause_steps", step_cnt - s0, 0);
        chk("pause_score", int'(score), 0);
        chk("pause_lives", int'(lives), 3);
        press_btn();
        chk("resume_state", int'(state), 1);
        s0 = step_cnt;
        tick();
        chk("resume_step", step_cnt - s0, 1);

        // miss + hit + press in one cycle
        hits(7);
        chk("seven_hits", int'(score), 7);
        btn = 1'b1;
        repeat (7) cyc();
        ball_y = 9'd475; paddle_hit = 1'b1;
        cyc();
        ball_y = 9'd100; paddle_hit = 1'b0;
        repeat (5) cyc();
        btn = 1'b0;
        repeat (10) cyc();
        chk("combo_lives", int'(lives), 2);
        chk("combo_score", int'(score), 7);
        chk("combo_state", int'(state), 1);
        hits(1);
        chk("eighth_hit", int'(score), 8);
        s0 = step_cnt;
        repeat (4) tick();
        chk("post8_steps", step_cnt - s0, EXP_STEPS);

        paddle_hit = 1'b1;
        repeat (260) cyc();
        paddle_hit = 1'b0;
        cyc();
        chk("score_sat", int'(score), 255);

        rst_n = 1'b0;
        #1;
        chk("async_rst_state", int'(state), 0);
        chk("async_rst_score", int'(score), 0);
        cyc(); cyc();
        chk("midrst_lives", int'(lives), 0);
        rst_n = 1'b1;
        s0 = step_cnt; l0 = load_cnt;
        repeat (6) cyc();
        chk("midrst_steps", step_cnt - s0, 0);
        chk("midrst_loads", load_cnt - l0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
